// File: rtl/instruction_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_cache_pkg
//  Description : Shared geometry constants, FSM state encoding and word
//                selection helper for the direct-mapped instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_cache_pkg;

  // Address split: [9:7] tag, [6:4] index, [3:2] word offset, [1:0] byte
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int NUM_BLOCKS = 8;
  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 128;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;

  localparam int TAG_LSB    = 7;
  localparam int INDEX_LSB  = 4;
  localparam int OFFSET_LSB = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

  // Pick one 32-bit word out of a 128-bit block; word0 lives in the low bits
  function automatic logic [WORD_W-1:0] select_word(
    input logic [BLOCK_W-1:0]  blk,
    input logic [OFFSET_W-1:0] off
  );
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = blk[31:0];
      2'd1:    w = blk[63:32];
      2'd2:    w = blk[95:64];
      default: w = blk[127:96];
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_cache_array.sv
`default_nettype none
// ============================================================================
//  Module      : icache_array
//  Description : Valid/tag/data storage for the instruction cache. One
//                synchronous write port, one combinational read port. Only
//                the valid bits are cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_array
  import instruction_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [INDEX_W-1:0]   i_wr_index,
  input  logic [TAG_W-1:0]     i_wr_tag,
  input  logic [BLOCK_W-1:0]   i_wr_data,
  input  logic [INDEX_W-1:0]   i_rd_index,
  output logic                 o_rd_valid,
  output logic [TAG_W-1:0]     o_rd_tag,
  output logic [BLOCK_W-1:0]   o_rd_data
);

  logic [NUM_BLOCKS-1:0] w_valid;
  logic [TAG_W-1:0]      w_tag  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    w_data [NUM_BLOCKS];

  for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_entry
    logic               w_sel;
    logic               valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q,   tag_d;
    logic [BLOCK_W-1:0] data_q,  data_d;

    assign w_sel = i_wr_en && (i_wr_index == INDEX_W'(g));

    // Next-state for this entry: a write installs a fresh valid block
    always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (w_sel) begin
        valid_d = 1'b1;
        tag_d   = i_wr_tag;
        data_d  = i_wr_data;
      end
    end

    // Valid bit is the only state that reset has to clear
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    // Tag and data keep their contents across reset
    always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end

    assign w_valid[g] = valid_q;
    assign w_tag[g]   = tag_q;
    assign w_data[g]  = data_q;
  end

  assign o_rd_valid = w_valid[i_rd_index];
  assign o_rd_tag   = w_tag[i_rd_index];
  assign o_rd_data  = w_data[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_cache
//  Description : 8-block x 16-byte direct-mapped read-only instruction cache
//                with zero-latency hits and a three-state refill FSM
//                (IDLE -> MEM_READ -> UPDATE).
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_cache
  import instruction_cache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           ADDRESS,
  input  logic                  READ,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic                w_unused_addr;

  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [BLOCK_W-1:0]  w_rd_data;
  logic                w_hit;
  logic                w_wr_en;

  state_e              state_q, state_d;
  logic                mem_read_q, mem_read_d;

  // The PC holds ADDRESS stable while stalled, so it is used directly
  assign w_tag         = ADDRESS[TAG_LSB    +: TAG_W];
  assign w_index       = ADDRESS[INDEX_LSB  +: INDEX_W];
  assign w_offset      = ADDRESS[OFFSET_LSB +: OFFSET_W];
  assign w_unused_addr = ^{ADDRESS[31:10], ADDRESS[1:0]};

  icache_array u_array (
    .clk        (CLK),
    .rst        (RESET),
    .i_wr_en    (w_wr_en),
    .i_wr_index (w_index),
    .i_wr_tag   (w_tag),
    .i_wr_data  (MEM_READDATA),
    .i_rd_index (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data)
  );

  // While RESET is high every entry is treated as invalid
  assign w_hit = READ && !RESET && w_rd_valid && (w_rd_tag == w_tag);

  // Refill write happens on the UPDATE edge unless reset aborts it
  assign w_wr_en = (state_q == ST_UPDATE) && !RESET;

  assign INSTRUCTION = select_word(w_rd_data, w_offset);
  assign BUSYWAIT    = (READ && !w_hit) || (state_q != ST_IDLE);
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = mem_read_q ? {w_tag, w_index} : '0;

  // Refill sequencing: miss -> wait for memory -> install block -> idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (READ && !w_hit) begin
          state_d = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        if (!MEM_BUSYWAIT) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    mem_read_d = (state_d == ST_MEM_READ);
  end

  // State and the registered memory request; reset abandons any refill
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      mem_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_read_q <= mem_read_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_cache
//  Description : Scoreboard bench for instruction_cache with a behavioural
//                instruction memory (5-cycle busy window per block read).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  ADDRESS;
  logic         READ;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_tests;
  int n_fail;
  logic [31:0] exp_q[$];

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .READ         (READ),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: word w of block b is C0DE_bb0w
  function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
    return {16'hC0DE, 2'b00, blk, 6'b000000, w};
  endfunction

  function automatic logic [127:0] mem_block(input logic [5:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Instruction memory: busy for 5 cycles after a request, then data + idle
  initial begin
    int cnt;
    bit active;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    active = 1'b0;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (MEM_READ !== 1'b1) begin
        active = 1'b0;
        MEM_BUSYWAIT = 1'b0;
      end else if (!active) begin
        active = 1'b1;
        cnt = 0;
        MEM_BUSYWAIT = 1'b1;
      end else if (MEM_BUSYWAIT) begin
        cnt++;
        if (cnt == 5) begin
          MEM_READDATA = mem_block(MEM_ADDRESS);
          MEM_BUSYWAIT = 1'b0;
        end
      end
    end
  end

  // Monitor: every delivered instruction is checked against the scoreboard
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge CLK);
      if (READ === 1'b1 && BUSYWAIT === 1'b0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_instruction addr=%h got=%h exp=none", ADDRESS, INSTRUCTION);
        end else begin
          exp = exp_q.pop_front();
          if (INSTRUCTION !== exp) begin
            n_fail++;
            $display("FAIL instruction addr=%h got=%h exp=%h", ADDRESS, INSTRUCTION, exp);
          end
        end
      end
    end
  end

  // Issue one fetch (called just after a rising edge) and wait for delivery
  task automatic fetch(input logic [31:0] addr, input bit miss,
                       input logic [5:0] exp_maddr, input logic [31:0] exp_instr);
    int         busy_cycles = 0;
    bit         saw_mr = 1'b0;
    bit         done = 1'b0;
    logic [5:0] maddr = '0;
    exp_q.push_back(exp_instr);
    ADDRESS = addr;
    READ    = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (MEM_READ === 1'b1 && !saw_mr) begin
        saw_mr = 1'b1;
        maddr  = MEM_ADDRESS;
      end
      if (BUSYWAIT === 1'b0) done = 1'b1;
      else busy_cycles++;
    end
    check("fetch_completed", 32'(done), 32'd1);
    check("busy_cycles", 32'(busy_cycles), miss ? 32'd8 : 32'd0);
    check("mem_read_seen", 32'(saw_mr), 32'(miss));
    if (miss) check("mem_address", 32'(maddr), 32'(exp_maddr));
    @(posedge CLK); #1;
    READ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RESET   = 1'b1;
    READ    = 1'b0;
    ADDRESS = 32'h0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_busywait", 32'(BUSYWAIT), 32'd0);
    check("reset_mem_read", 32'(MEM_READ), 32'd0);
    check("reset_mem_address", 32'(MEM_ADDRESS), 32'd0);
    READ = 1'b1;
    #1;
    check("reset_read_busywait", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    check("reset_read_no_mem_read", 32'(MEM_READ), 32'd0);
    READ  = 1'b0;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Cold miss on block 0 then sequential hits
    fetch(32'h000, 1'b1, 6'h00, 32'hC0DE_0000);
    fetch(32'h004, 1'b0, 6'h00, 32'hC0DE_0001);
    fetch(32'h008, 1'b0, 6'h00, 32'hC0DE_0002);
    fetch(32'h00C, 1'b0, 6'h00, 32'hC0DE_0003);

    // Conflict on index 1
    fetch(32'h010, 1'b1, 6'h01, 32'hC0DE_0100);
    fetch(32'h090, 1'b1, 6'h09, 32'hC0DE_0900);
    fetch(32'h010, 1'b1, 6'h01, 32'hC0DE_0100);
    fetch(32'h014, 1'b0, 6'h00, 32'hC0DE_0101);

    // READ low: no stall, no memory traffic
    ADDRESS = 32'h090;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("idle_busywait", 32'(BUSYWAIT), 32'd0);
      check("idle_mem_read", 32'(MEM_READ), 32'd0);
    end
    @(posedge CLK); #1;

    // Upper address bits ignored; reset PC maps to block 0x3F word 3
    fetch(32'h400, 1'b0, 6'h00, 32'hC0DE_0000);
    fetch(32'hFFFF_FFFC, 1'b1, 6'h3F, 32'hC0DE_3F03);

    // Reset during the second cycle of MEM_READ aborts the refill
    ADDRESS = 32'h100;
    READ    = 1'b1;
    @(posedge CLK); #1;
    check("abort_mem_read_1st", 32'(MEM_READ), 32'd1);
    check("abort_mem_address", 32'(MEM_ADDRESS), 32'h10);
    @(posedge CLK); #1;
    check("abort_mem_read_2nd", 32'(MEM_READ), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_reset_busywait", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    READ  = 1'b0;
    @(negedge CLK);
    check("abort_mem_read_after", 32'(MEM_READ), 32'd0);
    check("abort_busywait_after", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK); #1;

    // Block 0 was invalidated and must be refetched
    fetch(32'h000, 1'b1, 6'h00, 32'hC0DE_0000);
    fetch(32'h008, 1'b0, 6'h00, 32'hC0DE_0002);

    repeat (2) @(posedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
